seg_display_scan_ctrl: RTL and testbench

- Parametrised N-digit multiplexed seven-segment driver.
- Replaces the fixed 4-digit, state-coded display with a wider, configurable one.
- Adds four features:
  - iterative binary-to-BCD conversion of a game score;
  - leading-zero blanking;
  - a blink mode for the pause state;
  - per-state text messages.
- Sits between the master state machine / score counter and the board display pins.

---
 rtl/seg_display_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_seg_display_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan_ctrl.sv
// seg_display_scan_ctrl: multiplexed N-digit seven-segment driver with
// iterative binary-to-BCD score conversion, leading-zero blanking,
// pause-state blinking and per-state text messages.
//
// Ports:
//   CLK         system clock
//   RESET       synchronous, active-high reset
//   MSM_STATE   master state: 0 idle, 1 play, 2 pause, 3 end
//   SCORE       binary score, captured on an accepted SCORE_LOAD
//   SCORE_LOAD  one-cycle pulse that starts a BCD conversion
//   CONV_BUSY   high while a conversion is running
//   SEG_SELECT  active-low one-hot digit enables, bit 0 = rightmost digit
//   DEC_OUT     active-low segments {DP,g,f,e,d,c,b,a}, DP always off

module seg_display_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int SCORE_WIDTH = 14,
   parameter int CLK_DIV     = 100000,
   parameter int BLINK_TICKS = 250
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [1:0]             MSM_STATE,
   input  logic [SCORE_WIDTH-1:0] SCORE,
   input  logic                   SCORE_LOAD,
   output logic                   CONV_BUSY,
   output logic [NUM_DIGITS-1:0]  SEG_SELECT,
   output logic [7:0]             DEC_OUT
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int CNT_W = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;
   localparam int BCD_W = 4 * NUM_DIGITS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_END   = 2'd3;

   localparam logic [7:0] GLYPH_BLANK = 8'hFF;
   localparam logic [7:0] GLYPH_P     = 8'h8C;
   localparam logic [7:0] GLYPH_L     = 8'hC7;
   localparam logic [7:0] GLYPH_A     = 8'h88;
   localparam logic [7:0] GLYPH_Y     = 8'h91;
   localparam logic [7:0] GLYPH_E     = 8'h86;
   localparam logic [7:0] GLYPH_N     = 8'hAB;
   localparam logic [7:0] GLYPH_D     = 8'hA1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   // Largest score that fits in the display; anything above shows all nines.
   localparam logic [63:0] MAX_SCORE = pow10(NUM_DIGITS) - 64'd1;
   localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

   function automatic logic [7:0] digit_font(input logic [3:0] v);
      logic [7:0] g;
      case (v)
         4'd0:    g = 8'hC0;
         4'd1:    g = 8'hF9;
         4'd2:    g = 8'hA4;
         4'd3:    g = 8'hB0;
         4'd4:    g = 8'h99;
         4'd5:    g = 8'h92;
         4'd6:    g = 8'h82;
         4'd7:    g = 8'hF8;
         4'd8:    g = 8'h80;
         4'd9:    g = 8'h90;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // ------------------------------------------------------------------
   // Refresh divider and digit scan index
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [IDX_W-1:0] digit_idx;
   logic [IDX_W-1:0] next_idx;

   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign next_idx = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ?
                     '0 : digit_idx + 1'b1;

   // ------------------------------------------------------------------
   // Blink phase: only advances in pause, otherwise parked visible
   // ------------------------------------------------------------------
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_on;

   always_ff @(posedge CLK) begin
      if (RESET || (MSM_STATE != ST_PAUSE)) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (tick) begin
         if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Binary-to-BCD conversion (double dabble, one bit per cycle)
   // ------------------------------------------------------------------
   typedef enum logic {
      CONV_IDLE,
      CONV_RUN
   } conv_state_t;

   conv_state_t            conv_state;
   conv_state_t            conv_next;
   logic                   load_accept;
   logic                   conv_done;
   logic [SCORE_WIDTH-1:0] shift_reg;
   logic [BCD_W-1:0]       bcd_acc;
   logic [BCD_W-1:0]       bcd_adj;
   logic [BCD_W-1:0]       bcd_next;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   ovf;
   logic [BCD_W-1:0]       disp_bcd;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         conv_state <= CONV_IDLE;
      end else begin
         conv_state <= conv_next;
      end
   end

   // A load coinciding with completion is dropped: it only counts in IDLE.
   always_comb begin
      conv_next   = conv_state;
      load_accept = 1'b0;
      conv_done   = 1'b0;
      unique case (conv_state)
         CONV_IDLE: begin
            if (SCORE_LOAD) begin
               load_accept = 1'b1;
               conv_next   = CONV_RUN;
            end
         end
         CONV_RUN: begin
            if (bit_cnt == CNT_W'(SCORE_WIDTH - 1)) begin
               conv_done = 1'b1;
               conv_next = CONV_IDLE;
            end
         end
      endcase
   end

   // Add 3 to every digit >= 5, then shift the next score bit in.
   // In-range scores never carry out of the top digit; overflowed
   // scores are replaced by all nines, so the dropped carry is harmless.
   always_comb begin
      bcd_adj = bcd_acc;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_acc[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
         end
      end
      bcd_next = BCD_W'({bcd_adj, shift_reg[SCORE_WIDTH-1]});
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         shift_reg <= '0;
         bcd_acc   <= '0;
         bit_cnt   <= '0;
         ovf       <= 1'b0;
         disp_bcd  <= '0;
      end else if (load_accept) begin
         shift_reg <= SCORE;
         bcd_acc   <= '0;
         bit_cnt   <= '0;
         ovf       <= (64'(SCORE) > MAX_SCORE);
      end else if (conv_state == CONV_RUN) begin
         shift_reg <= shift_reg << 1;
         bcd_acc   <= bcd_next;
         bit_cnt   <= bit_cnt + 1'b1;
         if (conv_done) begin
            disp_bcd <= ovf ? ALL_NINES : bcd_next;
         end
      end
   end

   assign CONV_BUSY = (conv_state == CONV_RUN);

   // ------------------------------------------------------------------
   // Leading-zero blanking: a digit shows if it or any higher digit
   // is non-zero; digit 0 always shows.
   // ------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] shown;

   always_comb begin
      logic seen;
      seen  = 1'b0;
      shown = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         seen     = seen | (disp_bcd[4*i +: 4] != 4'd0) | (i == 0);
         shown[i] = seen;
      end
   end

   // ------------------------------------------------------------------
   // Content for the digit about to be selected
   // ------------------------------------------------------------------
   logic [3:0]            sel_digit;
   logic                  sel_shown;
   logic [NUM_DIGITS-1:0] seg_next;
   logic [7:0]            dec_next;

   always_comb begin
      sel_digit = 4'd0;
      sel_shown = 1'b0;
      seg_next  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (next_idx == IDX_W'(i)) begin
            sel_digit   = disp_bcd[4*i +: 4];
            sel_shown   = shown[i];
            seg_next[i] = 1'b0;
         end
      end
   end

   always_comb begin
      dec_next = GLYPH_BLANK;
      unique case (MSM_STATE)
         ST_IDLE: begin
            if (next_idx == IDX_W'(3)) begin
               dec_next = GLYPH_P;
            end else if (next_idx == IDX_W'(2)) begin
               dec_next = GLYPH_L;
            end else if (next_idx == IDX_W'(1)) begin
               dec_next = GLYPH_A;
            end else if (next_idx == IDX_W'(0)) begin
               dec_next = GLYPH_Y;
            end
         end
         ST_PLAY: begin
            if (sel_shown) begin
               dec_next = digit_font(sel_digit);
            end
         end
         ST_PAUSE: begin
            if (sel_shown && blink_on) begin
               dec_next = digit_font(sel_digit);
            end
         end
         ST_END: begin
            if (next_idx == IDX_W'(2)) begin
               dec_next = GLYPH_E;
            end else if (next_idx == IDX_W'(1)) begin
               dec_next = GLYPH_N;
            end else if (next_idx == IDX_W'(0)) begin
               dec_next = GLYPH_D;
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output register: loads only on a tick, so state changes land
   // cleanly at digit-slot boundaries.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         digit_idx  <= IDX_W'(NUM_DIGITS - 1);
         SEG_SELECT <= '1;
         DEC_OUT    <= GLYPH_BLANK;
      end else if (tick) begin
         digit_idx  <= next_idx;
         SEG_SELECT <= seg_next;
         DEC_OUT    <= dec_next;
      end
   end

endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// tb_seg_display_scan_ctrl: scoreboard bench
// for seg_display_scan_ctrl.

module tb_seg_display_scan_ctrl;

  localparam int ND = 4;
  localparam int SW = 14;
  localparam int CD = 4;
  localparam int BT = 2;
  localparam int MAXV = 9999;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    msm_state;
  logic [SW-1:0] score;
  logic          score_load;
  logic          conv_busy;
  logic [ND-1:0] seg_select;
  logic [7:0]    dec_out;

  always #5 clk = ~clk;

  seg_display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SCORE_WIDTH(SW),
    .CLK_DIV    (CD),
    .BLINK_TICKS(BT)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .MSM_STATE (msm_state),
    .SCORE     (score),
    .SCORE_LOAD(score_load),
    .CONV_BUSY (conv_busy),
    .SEG_SELECT(seg_select),
    .DEC_OUT   (dec_out)
  );

  int    checks = 0;
  int    fails  = 0;
  string phase  = "reset";

  logic [ND+8:0] exp_q[$];

  int            m_cyc;
  int            m_ticks;
  int            m_pticks;
  int            m_val;
  int            m_pending;
  int            m_done_at;
  bit            m_busy;
  logic [ND-1:0] m_seg;
  logic [7:0]    m_dec;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] font(input int v);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[v];
  endfunction

  function automatic logic [7:0] exp_glyph(
    input int st, input int d,
    input int val, input bit on);
    logic [7:0] g;
    g = 8'hFF;
    case (st)
      0: begin
        if (d == 3) g = 8'h8C;
        else if (d == 2) g = 8'hC7;
        else if (d == 1) g = 8'h88;
        else if (d == 0) g = 8'h91;
      end
      3: begin
        if (d == 2) g = 8'h86;
        else if (d == 1) g = 8'hAB;
        else if (d == 0) g = 8'hA1;
      end
      default: begin
        if ((st == 2) && !on) g = 8'hFF;
        else if ((d != 0) && (val < pow10(d)))
          g = 8'hFF;
        else g = font((val / pow10(d)) % 10);
      end
    endcase
    return g;
  endfunction

  task automatic model_step();
    int st;
    int d;
    bit tick;
    bit on;
    st = int'(msm_state);
    if (rst) begin
      m_cyc    = 0;
      m_ticks  = 0;
      m_pticks = 0;
      m_val    = 0;
      m_busy   = 0;
      m_seg    = '1;
      m_dec    = 8'hFF;
    end else begin
      tick = ((m_cyc % CD) == CD - 1);
      if (st != 2) m_pticks = 0;
      if (tick) begin
        on = 1;
        if (st == 2) begin
          on = ((m_pticks / BT) % 2) == 0;
          m_pticks++;
        end
        m_ticks++;
        d     = (m_ticks - 1) % ND;
        m_seg = ~(ND'(1) << d);
        m_dec = exp_glyph(st, d, m_val, on);
      end
      if (m_busy && (m_cyc == m_done_at)) begin
        m_val  = m_pending;
        m_busy = 0;
      end else if (!m_busy && score_load) begin
        m_busy    = 1;
        m_done_at = m_cyc + SW;
        m_pending = (int'(score) > MAXV) ?
                    MAXV : int'(score);
      end
      m_cyc++;
    end
    exp_q.push_back({m_busy, m_seg, m_dec});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [ND+8:0] e;
    logic [ND+8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {conv_busy, seg_select, dec_out};
        checks++;
        if (got !== e) begin
          fails++;
          if (fails <= 40)
            $display("FAIL %s t=%0t got %b/%h/%h exp %b/%h/%h",
                     phase, $time, got[ND+8],
                     got[ND+7:8], got[7:0],
                     e[ND+8], e[ND+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int v);
    score      = SW'(v);
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    checks++;
    if ((conv_busy !== 1'b0) ||
        (seg_select !== {ND{1'b1}}) ||
        (dec_out !== 8'hFF)) begin
      fails++;
      $display("FAIL %s reset state t=%0t got %b/%h/%h",
               tag, $time, conv_busy,
               seg_select, dec_out);
    end
  endtask

  initial begin
    int bnd [9];
    int r;
    int n;
    bnd = '{9, 10, 99, 100, 999,
            1000, 9999, 10000, 16383};
    rst        = 1'b1;
    msm_state  = 2'd0;
    score      = '0;
    score_load = 1'b0;
    step(3);
    chk_reset("power_on");
    rst = 1'b0;
    phase = "idle_text";
    step(40);

    phase = "score_307";
    msm_state = 2'd1;
    load(307);
    step(5);
    load(9999);
    step(60);

    phase = "score_zero";
    load(0);
    n = 0;
    while (conv_busy && (n < SW + 4)) begin
      step(1);
      n++;
    end
    checks++;
    if (conv_busy || (n > SW)) begin
      fails++;
      $display("FAIL %s wait expired: busy=%b after %0d",
               phase, conv_busy, n);
    end
    step(30);

    phase = "overflow_12000";
    load(12000);
    step(40);

    phase = "boundaries";
    foreach (bnd[i]) begin
      load(bnd[i]);
      step(30);
    end

    phase = "coincide";
    load(1234);
    step(13);
    load(4321);
    step(30);
    load(42);
    step(30);

    phase = "blink";
    load(4567);
    step(20);
    msm_state = 2'd2;
    step(80);
    msm_state = 2'd1;
    step(20);
    msm_state = 2'd2;
    step(37);
    msm_state = 2'd3;
    step(20);

    phase = "random";
    repeat (1500) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)
        msm_state = 2'($urandom_range(0, 3));
      if ((r >= 3) && (r < 8)) begin
        if ($urandom_range(0, 1) == 1)
          score = SW'($urandom_range(0, 16383));
        else
          score = SW'($urandom_range(0, 120));
        score_load = 1'b1;
      end else begin
        score_load = 1'b0;
      end
      @(negedge clk);
    end
    score_load = 1'b0;

    phase = "reset_mid";
    msm_state = 2'd1;
    load(8888);
    step(22);
    load(55);
    step(6);
    rst = 1'b1;
    step(1);
    chk_reset("mid_conv");
    rst = 1'b0;
    step(40);
    msm_state = 2'd2;
    load(77);
    step(30);
    rst = 1'b1;
    step(2);
    chk_reset("mid_scan");
    rst = 1'b0;
    step(30);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
